// File: rtl/dz_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// dz_countdown_ctrl
//
// Sequencer for the 8x8 dot-matrix digit display.
//  * Countdown: after start, the digit code on num steps from START_NUM down
//    to 0. Each step takes TICK_DIV clock cycles. A one-cycle done pulse
//    marks the arrival at 0.
//  * Row scan: a free-running scanner selects one row at a time, active-low.
//    Each row stays selected for SCAN_DIV cycles. The scanner ignores
//    start, pause and clr.
//
// Optional build macro:
//   DZ_BLINK_EN - while in DONE, tick_cnt keeps running modulo TICK_DIV.
//                 The row output is blanked (8'hFF) during the second half of
//                 each period, so the final digit blinks. row_idx keeps
//                 scanning during blanking.
//                 Without the macro, DONE scans normally and tick_cnt holds 0.
//
// Parameters:
//   TICK_DIV  - clk cycles per digit step (>= 2)
//   SCAN_DIV  - clk cycles each row stays selected (>= 1)
//   START_NUM - first digit shown after start (0..7)
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   start    in   pulse; begins or restarts the countdown from IDLE/DONE
//   pause    in   level; freezes the countdown while high
//   clr      in   pulse; aborts and returns to IDLE (highest priority)
//   num      out  [2:0] digit code, registered
//   row_idx  out  [2:0] current scan row, registered
//   row      out  [7:0] active-low one-hot row select (or 8'hFF when blanked)
//   busy     out  high in RUN and PAUSE
//   done     out  one-cycle pulse when num reaches 0
// -----------------------------------------------------------------------------
module dz_countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned START_NUM = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  output logic [2:0] num,
  output logic [2:0] row_idx,
  output logic [7:0] row,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [2:0]    START3    = 3'(START_NUM);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    num_q, num_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    row_idx_q, row_idx_d;
  logic [7:0]    row_q, row_d;
  logic          blank_d;

  logic tick_wrap;
  logic scan_wrap;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign scan_wrap = (scan_q == SCAN_LAST);

  // Countdown next-state logic
  // NOTE: every signal gets a default at the top of the block. Without that,
  // any path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    tick_d  = tick_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (clr) begin
      state_d = S_IDLE;
      num_d   = START3;
      tick_d  = '0;
      busy_d  = 1'b0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      tick_d = '0;
      if (START3 == 3'd0) begin
        // Nothing to count: go straight to DONE and announce it.
        state_d = S_DONE;
        num_d   = 3'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        num_d   = START3;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          num_d  = START3;
          tick_d = '0;
        end
        // RUN and PAUSE share one path. A cycle counts only while pause is
        // low, so the cycle that releases PAUSE already counts. The total
        // delay therefore equals exactly the number of cycles pause was high.
        S_RUN, S_PAUSE: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
            if (tick_wrap) begin
              tick_d = '0;
              if (num_q <= 3'd1) begin
                num_d   = 3'd0;
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                num_d = num_q - 3'd1;
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_DONE: begin
          num_d = 3'd0;
`ifdef DZ_BLINK_EN
          tick_d = tick_wrap ? '0 : tick_q + TW'(1);
`else
          tick_d = '0;
`endif
        end
        default: begin
          state_d = S_IDLE;
          num_d   = START3;
          tick_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Row scanner next-state logic. It runs freely in every state.
  always_comb begin
    scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    row_idx_d = scan_wrap ? row_idx_q + 3'd1 : row_idx_q;
`ifdef DZ_BLINK_EN
    blank_d   = (state_d == S_DONE) && (tick_d >= TW'(TICK_DIV / 2));
`else
    blank_d   = 1'b0;
`endif
    // row is built from the next-cycle values, so it stays in step with
    // row_idx and with the blanking window.
    row_d     = blank_d ? 8'hFF : ~(8'b1 << row_idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= START3;
      tick_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      row_idx_q <= 3'd0;
      row_q     <= 8'hFE;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scan_q    <= scan_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
    end
  end

  assign num     = num_q;
  assign row_idx = row_idx_q;
  assign row     = row_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dz_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dz_countdown_ctrl
//
// Self-checking bench for dz_countdown_ctrl with TICK_DIV=10, SCAN_DIV=2 and
// START_NUM=5.
//  * Every cycle, all outputs are compared against a behavioural model. The
//    model tracks the countdown as a count of "counted cycles" since start,
//    and the scanner as the number of cycles since reset.
//  * A table of {inputs, repeat, expected} records covers the scripted
//    scenarios.
//  * Hand-written sequences cover reset mid-run.
//  * A randomized phase follows.
// The blink expectations follow DZ_BLINK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_dz_countdown_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int SCAN_DIV  = 2;
  localparam int START_NUM = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       clr;
  logic [2:0] num;
  logic [2:0] row_idx;
  logic [7:0] row;
  logic       busy;
  logic       done;

  dz_countdown_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .START_NUM(START_NUM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .clr    (clr),
    .num    (num),
    .row_idx(row_idx),
    .row    (row),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_ACTIVE, M_FINISHED} mode_e;

  mode_e m_mode;
  int    m_cyc;      // clock edges since reset release (drives the scanner)
  int    m_elapsed;  // counted (non-paused) cycles since the last start
  int    m_age;      // cycles spent in the finished state
  bit    m_done;
  bit    prev_done;

  function automatic void model_reset();
    m_mode    = M_IDLE;
    m_cyc     = 0;
    m_elapsed = 0;
    m_age     = 0;
    m_done    = 1'b0;
    prev_done = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit p, input bit c);
    m_cyc++;
    m_done = 1'b0;
    if (c) begin
      m_mode = M_IDLE;
    end else if (s && m_mode != M_ACTIVE) begin
      m_mode    = M_ACTIVE;
      m_elapsed = 0;
    end else if (m_mode == M_ACTIVE) begin
      if (!p) begin
        m_elapsed++;
        if (m_elapsed == START_NUM * TICK_DIV) begin
          m_mode = M_FINISHED;
          m_done = 1'b1;
          m_age  = 0;
        end
      end
    end else if (m_mode == M_FINISHED) begin
      m_age++;
    end
  endfunction

  task automatic check_model();
    int exp_num;
    int exp_idx;
    int exp_row;
    bit blank;
    case (m_mode)
      M_IDLE:   exp_num = START_NUM;
      M_ACTIVE: exp_num = START_NUM - m_elapsed / TICK_DIV;
      default:  exp_num = 0;
    endcase
    exp_idx = (m_cyc / SCAN_DIV) % 8;
    blank   = 1'b0;
`ifdef DZ_BLINK_EN
    blank   = (m_mode == M_FINISHED) && ((m_age % TICK_DIV) >= TICK_DIV / 2);
`endif
    exp_row = blank ? 8'hFF : (8'hFF ^ (1 << exp_idx));
    check("num", int'(num), exp_num);
    check("busy", int'(busy), int'(m_mode == M_ACTIVE));
    check("done", int'(done), int'(m_done));
    check("row_idx", int'(row_idx), exp_idx);
    check("row", int'(row), exp_row);
    check("done_not_consecutive", int'(prev_done && done), 0);
    prev_done = done;
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then check
  // on the next falling edge.
  task automatic cycle(input bit s, input bit p, input bit c);
    start = s;
    pause = p;
    clr   = c;
    @(posedge clk);
    model_step(s, p, c);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_num"}, int'(num), START_NUM);
    check({tag, "_row_idx"}, int'(row_idx), 0);
    check({tag, "_row"}, int'(row), 8'hFE);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Scripted vectors: apply {start,pause,clr} for n cycles, then compare.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit    s;
    bit    p;
    bit    c;
    int    n;
    int    e_num;
    bit    e_busy;
    bit    e_done;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit s, input bit p, input bit c, input int n,
                              input int e_num, input bit e_busy, input bit e_done,
                              input string name);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.n = n;
    v.e_num = e_num; v.e_busy = e_busy; v.e_done = e_done; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    // Idle, then a plain countdown.
    add(0, 0, 0, 40, 5, 0, 0, "idle40");
    add(1, 0, 0,  1, 5, 1, 0, "start_busy");
    add(0, 0, 0,  9, 5, 1, 0, "before_step1");
    add(0, 0, 0,  1, 4, 1, 0, "step1");
    add(0, 0, 0, 10, 3, 1, 0, "step2");
    add(0, 0, 0, 10, 2, 1, 0, "step3");
    add(0, 0, 0, 10, 1, 1, 0, "step4");
    add(0, 0, 0,  9, 1, 1, 0, "before_done");
    add(0, 0, 0,  1, 0, 0, 1, "done_at_50");
    add(0, 0, 0,  1, 0, 0, 0, "done_one_cycle");
    add(0, 0, 0,  7, 0, 0, 0, "num_stays_0");
    // Pause from cycle 15 for 7 cycles; done 57 cycles after start.
    add(1, 0, 0,  1, 5, 1, 0, "restart_from_done");
    add(0, 0, 0, 14, 4, 1, 0, "pre_pause");
    add(0, 1, 0,  7, 4, 1, 0, "paused_frozen");
    add(0, 0, 0, 35, 1, 1, 0, "before_done_paused");
    add(0, 0, 0,  1, 0, 0, 1, "done_at_57");
    add(0, 0, 0,  1, 0, 0, 0, "done_pulse_end");
    // clr at num=2, then start+clr together.
    add(1, 0, 0,  1, 5, 1, 0, "start_for_clr");
    add(0, 0, 0, 30, 2, 1, 0, "num_2");
    add(0, 0, 1,  1, 5, 0, 0, "clr_idle");
    add(1, 0, 1,  1, 5, 0, 0, "start_clr_idle");
    add(0, 0, 0, 60, 5, 0, 0, "no_done_after_clr");
    // Start pulses in RUN do not disturb the timing.
    add(1, 0, 0,  1, 5, 1, 0, "start_ignore_run");
    add(0, 0, 0, 12, 4, 1, 0, "run_12");
    add(1, 0, 0,  1, 4, 1, 0, "start_in_run");
    add(0, 0, 0, 20, 2, 1, 0, "run_33");
    add(1, 0, 0,  1, 2, 1, 0, "start_in_run2");
    add(0, 0, 0, 15, 1, 1, 0, "run_49");
    add(0, 0, 0,  1, 0, 0, 1, "done_unaffected");
    add(0, 0, 0, 23, 0, 0, 0, "hold_done");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit p_lvl;
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    clr   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    model_reset();

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) cycle(vecs[i].s, vecs[i].p, vecs[i].c);
      check({vecs[i].name, "_num"}, int'(num), vecs[i].e_num);
      check({vecs[i].name, "_busy"}, int'(busy), int'(vecs[i].e_busy));
      check({vecs[i].name, "_done"}, int'(done), int'(vecs[i].e_done));
    end

    // Reset asserted in the middle of a run acts immediately, with no edge.
    cycle(1, 0, 0);
    for (int k = 0; k < 23; k++) cycle(0, 0, 0);
    #1 rst = 1'b1;
    #1 check_reset_values("midrun_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) cycle(0, 0, 0);

    // Randomized phase.
    p_lvl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bit s;
      bit c;
      if ($urandom_range(0, 19) == 0) p_lvl = ~p_lvl;
      s = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 149) == 0);
      cycle(s, p_lvl, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
